// File: rtl/fetch_queue_pkg.sv
// Types and helpers shared by the fetch queue and its storage array.
`include "define.v"

package fetch_queue_pkg;

  localparam logic [31:0] IM_BASE_DEF  = `IM_BASE;
  localparam logic [31:0] IM_LIMIT_DEF = `IM_LIMIT;
  localparam logic [31:0] PC_RESET_DEF = `PC_RESET;
  localparam logic [31:0] NOP_INSTR    = `INSTR_NOP;

  // One buffered fetch: address, instruction word and address-error flag.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fq_entry_t;

  localparam int ENTRY_W = $bits(fq_entry_t);

  // Fetch address error: misaligned word or outside the instruction-memory window.
  function automatic logic fetch_adel(input logic [31:0] pc,
                                      input logic [31:0] base,
                                      input logic [31:0] limit);
    return (pc[1:0] != 2'b00) || (pc < base) || (pc > limit);
  endfunction

endpackage

// File: rtl/define.v
// Shared fetch-side constants: legal instruction-memory window, PC reset value, nop encoding.
`ifndef FETCH_QUEUE_DEFINE_V
`define FETCH_QUEUE_DEFINE_V

`define IM_BASE    32'h0000_3000
`define IM_LIMIT   32'h0000_6FFC
`define PC_RESET   `IM_BASE
`define INSTR_NOP  32'h0000_0000

`endif

// File: rtl/fetch_queue_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, storage not reset.
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry on an enqueue.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between the PC register / instruction memory and the decode stage.
// Buffers {PC, instruction, adel} per fetch, hands entries out over valid/ready,
// and throttles the PC through PC_en so a fetch is never dropped or duplicated.
`include "define.v"

module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2,
  parameter logic [31:0] IM_BASE  = `IM_BASE,
  parameter logic [31:0] IM_LIMIT = `IM_LIMIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      F_PC,
  input  logic [31:0]      F_Instr,
  output logic             PC_en,
  input  logic             flush,
  input  logic             D_ready,
  output logic             D_valid,
  output logic [31:0]      D_PC,
  output logic [31:0]      D_Instr,
  output logic             D_AdEL,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE    = 1;
  localparam logic [PTR_W-1:0] PTR_ONE    = 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             enq;
  logic             deq;
  fq_entry_t        wr_entry;
  fq_entry_t        rd_entry;
  logic [ENTRY_W-1:0] rd_bits;

  // Handshake terms; PC_en depends on registered occupancy and flush only.
  always_comb begin
    full  = (count == FULL_COUNT);
    empty = (count == '0);
    PC_en = ~full | flush;
    enq   = PC_en & ~flush;
    deq   = ~empty & D_ready & ~flush;
  end

  // Build the entry for this cycle's fetch; faulting addresses carry a nop.
  always_comb begin
    wr_entry.pc    = F_PC;
    wr_entry.adel  = fetch_adel(F_PC, IM_BASE, IM_LIMIT);
    wr_entry.instr = wr_entry.adel ? NOP_INSTR : F_Instr;
  end

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (enq & ~reset),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_bits)
  );

  assign rd_entry = fq_entry_t'(rd_bits);

  // Pointer and occupancy update; reset beats flush, flush beats enq/deq.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Head outputs are zeroed when empty so stale storage never leaks out.
  always_comb begin
    D_valid = ~empty;
    D_PC    = D_valid ? rd_entry.pc    : 32'h0;
    D_Instr = D_valid ? rd_entry.instr : 32'h0;
    D_AdEL  = D_valid ? rd_entry.adel  : 1'b0;
  end

endmodule
